// File: rtl/bsg_manycore_spmd_load_receiver.sv
// Tile-side SPMD program-load endpoint: buffers network packets, turns stores into
// byte-masked memory writes, clears freeze on release, and drops/flags bad packets.
module bsg_manycore_spmd_load_receiver
  #(parameter int data_width_p = 32
  , parameter int addr_width_p = 32
  , parameter int num_rows_p   = -1
  , parameter int num_cols_p   = -1
  , parameter int mem_size_p   = -1
  , localparam int y_cord_width_lp = ((num_rows_p + 1) <= 1) ? 1 : $clog2(num_rows_p + 1)
  , localparam int x_cord_width_lp = (num_cols_p <= 1) ? 1 : $clog2(num_cols_p)
  , localparam int packet_width_lp = addr_width_p + 2 + 4 + data_width_p
                                     + y_cord_width_lp + x_cord_width_lp
  )
  ( input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic                       v_i
  , input  logic [packet_width_lp-1:0] data_i
  , output logic                       ready_o
  , input  logic [x_cord_width_lp-1:0] my_x_i
  , input  logic [y_cord_width_lp-1:0] my_y_i
  , output logic                       mem_v_o
  , output logic [addr_width_p-3:0]    mem_addr_o
  , output logic [data_width_p-1:0]    mem_data_o
  , output logic [3:0]                 mem_mask_o
  , input  logic                       mem_yumi_i
  , output logic                       freeze_o
  , output logic [31:0]                words_o
  , output logic                       err_v_o
  , output logic [1:0]                 err_code_o
  );

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    logic [1:0]                 op;
    logic [3:0]                 op_ex;
    logic [data_width_p-1:0]    data;
    logic [y_cord_width_lp-1:0] y_cord;
    logic [x_cord_width_lp-1:0] x_cord;
  } bsg_manycore_orig_packet_s;

  localparam logic [1:0] op_store_lp   = 2'b01;
  localparam logic [1:0] op_release_lp = 2'b10;
  localparam logic [addr_width_p-1:0] mem_size_lp = addr_width_p'(mem_size_p);

  bsg_manycore_orig_packet_s buf_r [2];
  logic       wr_ptr_r, rd_ptr_r;
  logic [1:0] count_r;

  bsg_manycore_orig_packet_s head;
  logic head_v, enq, deq;
  logic drop, is_store, is_release;
  logic [1:0] drop_code;

  assign head    = buf_r[rd_ptr_r];
  assign head_v  = (count_r != 2'd0);
  assign ready_o = ~reset_i & (count_r != 2'd2);
  assign enq     = v_i & ready_o;

  // Classification priority: coordinate, then op legality, then store address.
  always_comb begin
    drop       = 1'b0;
    drop_code  = 2'b00;
    is_store   = 1'b0;
    is_release = 1'b0;
    if ((head.x_cord != my_x_i) || (head.y_cord != my_y_i)) begin
      drop      = 1'b1;
      drop_code = 2'b01;
    end else if ((head.op != op_store_lp) && (head.op != op_release_lp)) begin
      drop      = 1'b1;
      drop_code = 2'b11;
    end else if ((head.op == op_store_lp)
                 && ((head.addr[1:0] != 2'b00) || (head.addr >= mem_size_lp))) begin
      drop      = 1'b1;
      drop_code = 2'b10;
    end else if (head.op == op_store_lp) begin
      is_store = 1'b1;
    end else begin
      is_release = 1'b1;
    end
  end

  assign mem_v_o    = ~reset_i & head_v & is_store;
  assign mem_addr_o = head.addr[addr_width_p-1:2];
  assign mem_data_o = head.data;
  assign mem_mask_o = head.op_ex;

  assign deq = head_v & (drop | is_release | (is_store & mem_yumi_i));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq) begin
        buf_r[wr_ptr_r] <= bsg_manycore_orig_packet_s'(data_i);
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Status registers; err_code_o keeps the last drop reason between pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_o   <= 1'b1;
      words_o    <= '0;
      err_v_o    <= 1'b0;
      err_code_o <= 2'b00;
    end else begin
      err_v_o <= head_v & drop;
      if (head_v & drop) err_code_o <= drop_code;
      if (head_v & is_release) freeze_o <= 1'b0;
      if (mem_v_o & mem_yumi_i && (words_o != '1)) words_o <= words_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_spmd_load_receiver.sv
// Directed bench for the SPMD load receiver: streaming, back-pressure, drops, release, reset, masks.
module tb_bsg_manycore_spmd_load_receiver;

  localparam int XW = 2;
  localparam int YW = 2;
  localparam int PW = 32 + 2 + 4 + 32 + YW + XW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic [PW-1:0] data_i;
  logic          ready_o;
  logic [XW-1:0] my_x_i;
  logic [YW-1:0] my_y_i;
  logic          mem_v_o;
  logic [29:0]   mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [3:0]    mem_mask_o;
  logic          mem_yumi_i;
  logic          freeze_o;
  logic [31:0]   words_o;
  logic          err_v_o;
  logic [1:0]    err_code_o;

  int checks = 0;
  int errors = 0;

  logic [29:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [3:0]  wr_mask_q [$];
  logic [1:0]  err_q     [$];

  bsg_manycore_spmd_load_receiver #(
    .data_width_p(32), .addr_width_p(32), .num_rows_p(2), .num_cols_p(4), .mem_size_p(64)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .my_x_i(my_x_i), .my_y_i(my_y_i), .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i),
    .freeze_o(freeze_o), .words_o(words_o), .err_v_o(err_v_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  // Record completed writes and error pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset_i && mem_v_o && mem_yumi_i) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
      wr_mask_q.push_back(mem_mask_o);
    end
    if (err_v_o) err_q.push_back(err_code_o);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                           input logic [1:0] op, input logic [3:0] op_ex,
                                           input logic [31:0] addr, input logic [31:0] data);
    return {addr, op, op_ex, data, y, x};
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a packet until it is accepted, with a bounded wait.
  task automatic send(input logic [PW-1:0] pkt);
    bit done = 0;
    v_i    = 1'b1;
    data_i = pkt;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ready_o) done = 1;
      step();
    end
    v_i = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  int base;

  initial begin
    reset_i    = 1'b1;
    v_i        = 1'b0;
    data_i     = '0;
    my_x_i     = 2'd2;
    my_y_i     = 2'd1;
    mem_yumi_i = 1'b1;
    step(3);
    check("rst_ready",  {63'd0, ready_o}, 64'd0);
    check("rst_mem_v",  {63'd0, mem_v_o}, 64'd0);
    check("rst_freeze", {63'd0, freeze_o}, 64'd1);
    check("rst_words",  {32'd0, words_o}, 64'd0);
    check("rst_err_v",  {63'd0, err_v_o}, 64'd0);
    check("rst_err_code", {62'd0, err_code_o}, 64'd0);
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, ready_o}, 64'd1);

    // Streaming stores with memory always accepting.
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd0, 32'hA0));
    check("first_latency_mem_v", {63'd0, mem_v_o}, 64'd1);
    check("first_addr", {34'd0, mem_addr_o}, 64'd0);
    for (int k = 1; k < 4; k++) send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'(4 * k), 32'(32'hA0 + k)));
    step(4);
    check("stream_words", {32'd0, words_o}, 64'd4);
    check("stream_freeze", {63'd0, freeze_o}, 64'd1);
    check("stream_count", 64'(wr_addr_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
      check("stream_addr", {34'd0, wr_addr_q[k]}, 64'(k));
      check("stream_data", {32'd0, wr_data_q[k]}, 64'(32'hA0 + k));
      check("stream_mask", {60'd0, wr_mask_q[k]}, 64'hF);
    end

    // Back-pressure: memory stalls, buffer absorbs two then refuses.
    base = wr_addr_q.size();
    mem_yumi_i = 1'b0;
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd0, 32'hA0));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd4, 32'hA1));
    check("bp_ready_low", {63'd0, ready_o}, 64'd0);
    v_i    = 1'b1;
    data_i = mk_pkt(2, 1, 2'b01, 4'b1111, 32'd8, 32'hA2);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_v", {63'd0, mem_v_o}, 64'd1);
      check("bp_hold_addr", {34'd0, mem_addr_o}, 64'd0);
      check("bp_hold_data", {32'd0, mem_data_o}, 64'hA0);
      step();
    end
    check("bp_ready_still_low", {63'd0, ready_o}, 64'd0);
    v_i = 1'b0;
    mem_yumi_i = 1'b1;
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd8, 32'hA2));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd12, 32'hA3));
    step(5);
    check("bp_count", 64'(wr_addr_q.size() - base), 64'd4);
    for (int k = 0; k < 4 && base + k < wr_addr_q.size(); k++) begin
      check("bp_addr", {34'd0, wr_addr_q[base + k]}, 64'(k));
      check("bp_data", {32'd0, wr_data_q[base + k]}, 64'(32'hA0 + k));
    end
    check("bp_words", {32'd0, words_o}, 64'd8);

    // Malformed / misrouted packets.
    base = wr_addr_q.size();
    send(mk_pkt(3, 1, 2'b01, 4'b1111, 32'd0, 32'h1));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd3, 32'h2));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'd64, 32'h3));
    send(mk_pkt(2, 1, 2'b00, 4'b1111, 32'd0, 32'h4));
    step(4);
    check("err_pulses", 64'(err_q.size()), 64'd4);
    if (err_q.size() == 4) begin
      check("err_code0", {62'd0, err_q[0]}, 64'd1);
      check("err_code1", {62'd0, err_q[1]}, 64'd2);
      check("err_code2", {62'd0, err_q[2]}, 64'd2);
      check("err_code3", {62'd0, err_q[3]}, 64'd3);
    end
    check("err_code_held", {62'd0, err_code_o}, 64'd3);
    check("err_no_write", 64'(wr_addr_q.size() - base), 64'd0);
    check("err_words", {32'd0, words_o}, 64'd8);
    check("err_freeze", {63'd0, freeze_o}, 64'd1);

    // Release: head visible this cycle, dequeued at the next edge which clears freeze.
    send(mk_pkt(2, 1, 2'b10, 4'b0000, 32'd0, 32'd0));
    check("rel_freeze_before", {63'd0, freeze_o}, 64'd1);
    step();
    check("rel_freeze_after", {63'd0, freeze_o}, 64'd0);
    base = wr_addr_q.size();
    send(mk_pkt(2, 1, 2'b10, 4'b0000, 32'd0, 32'd0));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'h10, 32'h55));
    step(3);
    check("rel2_freeze", {63'd0, freeze_o}, 64'd0);
    check("rel_store_count", 64'(wr_addr_q.size() - base), 64'd1);
    if (wr_addr_q.size() > base) begin
      check("rel_store_addr", {34'd0, wr_addr_q[base]}, 64'd4);
      check("rel_store_data", {32'd0, wr_data_q[base]}, 64'h55);
    end
    check("rel_words", {32'd0, words_o}, 64'd9);

    // Reset with one store pending at the memory and one buffered.
    mem_yumi_i = 1'b0;
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'h24, 32'h77));
    send(mk_pkt(2, 1, 2'b01, 4'b1111, 32'h28, 32'h78));
    check("pre_rst_mem_v", {63'd0, mem_v_o}, 64'd1);
    reset_i = 1'b1;
    step();
    check("mid_rst_mem_v", {63'd0, mem_v_o}, 64'd0);
    check("mid_rst_freeze", {63'd0, freeze_o}, 64'd1);
    check("mid_rst_words", {32'd0, words_o}, 64'd0);
    check("mid_rst_ready", {63'd0, ready_o}, 64'd0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", {63'd0, ready_o}, 64'd1);
    base = wr_addr_q.size();
    mem_yumi_i = 1'b1;
    step(5);
    check("no_stale_write", 64'(wr_addr_q.size() - base), 64'd0);
    check("no_stale_mem_v", {63'd0, mem_v_o}, 64'd0);

    // Partial byte mask.
    mem_yumi_i = 1'b0;
    send(mk_pkt(2, 1, 2'b01, 4'b0101, 32'h20, 32'h11223344));
    check("mask_v", {63'd0, mem_v_o}, 64'd1);
    check("mask_mask", {60'd0, mem_mask_o}, 64'h5);
    check("mask_addr", {34'd0, mem_addr_o}, 64'd8);
    check("mask_data", {32'd0, mem_data_o}, 64'h11223344);
    mem_yumi_i = 1'b1;
    step(3);
    check("mask_words", {32'd0, words_o}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
